// File: rtl/debug_display_ctrl_if.sv
// Bus between the processor debug taps and the seven-segment display controller.
// Master drives the channel data and controls, slave (the controller) drives the display.
interface debug_display_ctrl_if #(
   parameter int N_CH   = 8,
   parameter int SELW   = 3,
   parameter int WIDTH  = 16,
   parameter int DIGITS = 4
);
   logic [N_CH*WIDTH-1:0] ChanData;
   logic [SELW-1:0]       Sel;
   logic [1:0]            Mode;
   logic                  Snap;
   logic [DIGITS*7-1:0]   Seg;
   logic [SELW-1:0]       ActiveCh;
   logic                  SnapValid;

   modport master (
      output ChanData, Sel, Mode, Snap,
      input  Seg, ActiveCh, SnapValid
   );

   modport slave (
      input  ChanData, Sel, Mode, Snap,
      output Seg, ActiveCh, SnapValid
   );
endinterface

// File: rtl/debug_display_ctrl.sv
// Debug-display controller: live, frozen-snapshot, auto-scan and blank views of
// N_CH packed debug channels on DIGITS active-low seven-segment displays.
module debug_display_ctrl #(
   parameter int N_CH     = 8,
   parameter int SELW     = 3,
   parameter int WIDTH    = 16,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000000,
   parameter int LZB      = 0
) (
   input logic                 Clk,
   input logic                 Reset,
   debug_display_ctrl_if.slave bus
);
   localparam int NSLOT = 2 ** SELW;
   localparam int DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [SELW-1:0] CH_LAST  = SELW'(N_CH - 1);
   localparam logic [SELW:0]   NCH_L    = (SELW + 1)'(N_CH);

   typedef enum logic [1:0] {M_LIVE, M_FROZEN, M_SCAN, M_BLANK} mode_e;
   typedef enum logic [1:0] {K_HEX, K_DASH, K_BLANK} kind_e;

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'b0000001;
         4'h1: hex_glyph = 7'b1001111;
         4'h2: hex_glyph = 7'b0010010;
         4'h3: hex_glyph = 7'b0000110;
         4'h4: hex_glyph = 7'b1001100;
         4'h5: hex_glyph = 7'b0100100;
         4'h6: hex_glyph = 7'b0100000;
         4'h7: hex_glyph = 7'b0001111;
         4'h8: hex_glyph = 7'b0000000;
         4'h9: hex_glyph = 7'b0000100;
         4'hA: hex_glyph = 7'b0001000;
         4'hB: hex_glyph = 7'b1100000;
         4'hC: hex_glyph = 7'b0110001;
         4'hD: hex_glyph = 7'b1000010;
         4'hE: hex_glyph = 7'b0110000;
         default: hex_glyph = 7'b0111000;
      endcase
   endfunction

   mode_e mode;
   assign mode = mode_e'(bus.Mode);

   // Channels padded to the full select range so out-of-range Sel indexes zeros.
   logic [WIDTH-1:0] ch   [NSLOT];
   logic [WIDTH-1:0] bank [NSLOT];
   for (genvar c = 0; c < NSLOT; c++) begin : g_ch
      if (c < N_CH) begin : g_live
         assign ch[c] = bus.ChanData[c*WIDTH +: WIDTH];
      end else begin : g_pad
         assign ch[c] = '0;
      end
   end

   logic snap_q, snap_valid_q, snap_edge;
   assign snap_edge = bus.Snap & ~snap_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         snap_q       <= 1'b0;
         snap_valid_q <= 1'b0;
         for (int c = 0; c < NSLOT; c++) bank[c] <= '0;
      end else begin
         snap_q <= bus.Snap;
         if (snap_edge) begin
            snap_valid_q <= 1'b1;
            for (int c = 0; c < NSLOT; c++) bank[c] <= ch[c];
         end
      end
   end

   logic [DW-1:0]   div_q, div_d;
   logic [SELW-1:0] scan_q, scan_d;
   logic            in_scan_q;

   // The display register samples scan_d, so a fresh entry dwells SCAN_DIV edges on ch0.
   always_comb begin
      div_d  = div_q;
      scan_d = scan_q;
      if (mode == M_SCAN) begin
         if (!in_scan_q) begin
            div_d  = '0;
            scan_d = '0;
         end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            scan_d = (scan_q == CH_LAST) ? '0 : scan_q + 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   logic [WIDTH-1:0] val_d, val_p1;
   logic [SELW-1:0]  act_d, act_p1;
   kind_e            kind_d, kind_p1;
   logic             sel_ok;
   assign sel_ok = ({1'b0, bus.Sel} < NCH_L);

   always_comb begin
      val_d  = val_p1;
      act_d  = act_p1;
      kind_d = K_BLANK;
      case (mode)
         M_LIVE: begin
            val_d  = ch[bus.Sel];
            act_d  = bus.Sel;
            kind_d = sel_ok ? K_HEX : K_DASH;
         end
         M_FROZEN: begin
            val_d  = bank[bus.Sel];
            act_d  = bus.Sel;
            kind_d = sel_ok ? K_HEX : K_DASH;
         end
         M_SCAN: begin
            val_d  = ch[scan_d];
            act_d  = scan_d;
            kind_d = K_HEX;
         end
         default: kind_d = K_BLANK;
      endcase
   end

   // Stage p1: display register; control is reset, the data word is not.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         kind_p1   <= K_BLANK;
         act_p1    <= '0;
         div_q     <= '0;
         scan_q    <= '0;
         in_scan_q <= 1'b0;
      end else begin
         kind_p1   <= kind_d;
         act_p1    <= act_d;
         div_q     <= div_d;
         scan_q    <= scan_d;
         in_scan_q <= (mode == M_SCAN);
      end
   end

   always_ff @(posedge Clk) val_p1 <= val_d;

   logic [DIGITS*7-1:0] seg;
   logic                nz;
   logic [3:0]          nib;

   always_comb begin
      seg = '1;
      nz  = 1'b0;
      nib = '0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         nib = val_p1[d*4 +: 4];
         nz  = nz | (nib != 4'h0);
         case (kind_p1)
            K_HEX:   seg[d*7 +: 7] = (LZB != 0 && !nz && d != 0) ? 7'h7F : hex_glyph(nib);
            K_DASH:  seg[d*7 +: 7] = 7'b1111110;
            default: seg[d*7 +: 7] = 7'h7F;
         endcase
      end
   end

   assign bus.Seg       = seg;
   assign bus.ActiveCh  = act_p1;
   assign bus.SnapValid = snap_valid_q;
endmodule
